// File: rtl/uart_tx_button.sv
// UART transmitter for the button/UART lab datapath.
// A rising edge on the debounced send level, seen while idle, sends one frame:
// start bit, din[0..7] LSB first, optional parity bit, stop bit.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-low reset
//   send  - debounced transmit request level (rising edge starts a frame)
//   din   - byte to transmit, captured only when the frame is accepted
//   tx    - serial line, idles high, driven straight from a flop
//   busy  - high from frame acceptance through the last stop-bit cycle
//   done  - one-cycle pulse on the cycle after the stop bit completes
//
// state  | meaning
// IDLE   | line high, waiting for a send rising edge
// START  | start bit (low) on the line
// DATA   | data bits, LSB first, shreg[0] on the line
// PARITY | parity bit on the line
// STOP   | stop bit (high) on the line
module uart_tx_button #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter int PARITY_EN     = 1,
  parameter int PARITY_ODD    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int BIT_TICKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int CW        = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(BIT_TICKS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          send_d_q;

  logic accept;
  logic bit_end;

  assign accept  = send & ~send_d_q & (state_q == S_IDLE);
  assign bit_end = (cnt_q == LAST_TICK);

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (accept) begin
          shreg_d = din;
          par_d   = (^din) ^ (PARITY_ODD != 0);
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            if (PARITY_EN != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            // next bit is what lands in shreg[0] after this shift
            tx_d = shreg_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shreg_q  <= 8'd0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      // treat send as already high so a button held through reset is ignored
      send_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      send_d_q <= send;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_button.sv
module tb_uart_tx_button;

  logic       clk = 1'b0;
  logic       reset;
  logic       send_p, send_np;
  logic [7:0] din;
  logic       tx_p, busy_p, done_p;
  logic       tx_np, busy_np, done_np;

  always #5 clk = ~clk;

  uart_tx_button #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1)) dut_p (
    .clk(clk), .reset(reset), .send(send_p), .din(din),
    .tx(tx_p), .busy(busy_p), .done(done_p));

  uart_tx_button #(.CLK_FREQUENCY(1000), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(1)) dut_np (
    .clk(clk), .reset(reset), .send(send_np), .din(din),
    .tx(tx_np), .busy(busy_np), .done(done_np));

  typedef struct {
    bit       sel;     // 0 = parity instance, 1 = no-parity instance
    bit [7:0] d;
    int       hold;    // cycles send stays high
    int       re_at;   // frame cycle of a second send edge, -1 = none
    bit       mid_din; // flip din mid-frame
    int       extra;   // idle cycles checked after the done pulse
    bit       b2b;     // return at the done cycle so the next frame starts there
    bit       exp_par; // expected parity bit
    int       exp_len; // expected frame length in bits
  } vec_t;

  vec_t vt[10];
  bit   sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic set_send(input bit sel, input logic v);
    if (sel) send_np = v;
    else     send_p  = v;
  endtask

  function automatic logic send_at(input vec_t v, input int j);
    return (j < v.hold - 1) || (v.re_at >= 0 && j >= v.re_at && j < v.re_at + 3);
  endfunction

  task automatic run_frame(input int id, input vec_t v);
    logic t, b, dn;
    bit   cur;
    int   bad;
    int   n;
    n = v.exp_len;
    b = v.sel ? busy_np : busy_p;
    chk($sformatf("v%0d pre_busy", id), {31'd0, b}, 32'd0);
    din = v.d;
    set_send(v.sel, 1'b1);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(v.d[i]);
    if (n == 11) sb.push_back(v.exp_par);
    sb.push_back(1'b1);
    cur = 1'b0;
    bad = 0;
    for (int j = 0; j < n * 10; j++) begin
      @(negedge clk);
      t  = v.sel ? tx_np   : tx_p;
      b  = v.sel ? busy_np : busy_p;
      dn = v.sel ? done_np : done_p;
      if (j == 0) chk($sformatf("v%0d latency_tx", id), {31'd0, t}, 32'd0);
      if (j % 10 == 0) begin
        cur = sb.pop_front();
        bad = 0;
      end
      if (t !== cur || b !== 1'b1 || dn !== 1'b0) bad++;
      if (j % 10 == 9) chk($sformatf("v%0d slot%0d bad_cycles", id, j / 10), bad, 32'd0);
      set_send(v.sel, send_at(v, j));
      if (v.mid_din && j == 25) din = ~v.d;
    end
    chk($sformatf("v%0d sb_empty", id), sb.size(), 32'd0);
    @(negedge clk);
    t  = v.sel ? tx_np   : tx_p;
    b  = v.sel ? busy_np : busy_p;
    dn = v.sel ? done_np : done_p;
    chk($sformatf("v%0d done_cycle {done,busy,tx}", id), {29'd0, dn, b, t}, 32'h5);
    if (v.b2b) return;
    set_send(v.sel, send_at(v, n * 10));
    bad = 0;
    for (int k = 0; k <= v.extra; k++) begin
      @(negedge clk);
      t  = v.sel ? tx_np   : tx_p;
      b  = v.sel ? busy_np : busy_p;
      dn = v.sel ? done_np : done_p;
      if ({dn, b, t} !== 3'b001) bad++;
      set_send(v.sel, send_at(v, n * 10 + 1 + k));
    end
    chk($sformatf("v%0d idle_after bad_cycles", id), bad, 32'd0);
  endtask

  initial begin
    int bad;
    vec_t rv;
    //          sel  d      hold re_at mid extra b2b par len
    vt[0] = '{1'b0, 8'h41,   3,  -1, 1'b0,   5, 1'b0, 1'b1, 11};
    vt[1] = '{1'b0, 8'h01,   3,  -1, 1'b0,   5, 1'b0, 1'b0, 11};
    vt[2] = '{1'b0, 8'hFF,   3,  -1, 1'b0,   5, 1'b0, 1'b1, 11};
    vt[3] = '{1'b1, 8'h41,   3,  -1, 1'b0,   5, 1'b0, 1'b0, 10};
    vt[4] = '{1'b1, 8'h01,   3,  -1, 1'b0,   5, 1'b0, 1'b0, 10};
    vt[5] = '{1'b1, 8'hFF,   3,  -1, 1'b0,   5, 1'b0, 1'b0, 10};
    vt[6] = '{1'b0, 8'h41, 300,  -1, 1'b1, 200, 1'b0, 1'b1, 11};
    vt[7] = '{1'b0, 8'h5A,   3,  40, 1'b0,   5, 1'b0, 1'b1, 11};
    vt[8] = '{1'b0, 8'hA5,   3,  -1, 1'b0,   0, 1'b1, 1'b1, 11};
    vt[9] = '{1'b0, 8'h07,   3,  -1, 1'b0,   5, 1'b0, 1'b0, 11};

    reset = 1'b0;
    send_p = 1'b0;
    send_np = 1'b0;
    din = 8'h00;
    repeat (3) @(negedge clk);
    chk("in_reset {done,busy,tx} p", {29'd0, done_p, busy_p, tx_p}, 32'h1);
    chk("in_reset {done,busy,tx} np", {29'd0, done_np, busy_np, tx_np}, 32'h1);
    reset = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({done_p, busy_p, tx_p} !== 3'b001 || {done_np, busy_np, tx_np} !== 3'b001) bad++;
    end
    chk("post_reset idle bad_cycles", bad, 32'd0);

    for (int i = 0; i < 10; i++) run_frame(i, vt[i]);

    // reset in the middle of a frame
    din = 8'hC3;
    send_p = 1'b1;
    repeat (55) @(negedge clk);
    chk("mid_frame busy before reset", {31'd0, busy_p}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort {done,busy,tx}", {29'd0, done_p, busy_p, tx_p}, 32'h1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if ({done_p, busy_p, tx_p} !== 3'b001) bad++;
    end
    reset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if ({done_p, busy_p, tx_p} !== 3'b001) bad++;
    end
    chk("held_send after reset bad_cycles", bad, 32'd0);
    send_p = 1'b0;
    @(negedge clk);
    rv = '{1'b0, 8'h41, 3, -1, 1'b0, 5, 1'b0, 1'b1, 11};
    run_frame(10, rv);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
